// File: rtl/req_sync_pkg.sv
// Shared types and constants for the multi-channel request receiver.
// Protocol modes and per-channel handshake states.
package req_sync_pkg;

  localparam int MODE_4PHASE = 0;
  localparam int MODE_TOGGLE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/req_sync_ch.sv
// One request channel: synchroniser chain, handshake or toggle logic,
// and the sticky overflow flag.
module req_sync_ch
  import req_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = MODE_4PHASE
) (
  input  logic clk,
  input  logic rst,
  input  logic req_in,
  output logic ack_out,
  output logic evt_valid,
  input  logic evt_ready,
  output logic ovf,
  input  logic ovf_clr
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic sreq;
  logic ovf_set;
  logic ovf_q, ovf_d;

  // shift the raw request through the synchroniser chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_in};
  end

  // synchroniser flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= sync_d;
  end

  assign sreq = sync_q[SYNC_STAGES-1];

  if (MODE == MODE_TOGGLE) begin : g_toggle
    logic sdly_q, sdly_d;
    logic vld_q, vld_d;
    logic evt;

    // edge detect; an event merges into a pending one
    always_comb begin
      sdly_d  = sreq;
      evt     = sreq ^ sdly_q;
      vld_d   = vld_q;
      ovf_set = 1'b0;
      if (evt) begin
        vld_d = 1'b1;
        if (vld_q && !evt_ready) ovf_set = 1'b1;
      end else if (vld_q && evt_ready) begin
        vld_d = 1'b0;
      end
    end

    // delayed copy of sreq and pending flag
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sdly_q <= 1'b0;
        vld_q  <= 1'b0;
      end else begin
        sdly_q <= sdly_d;
        vld_q  <= vld_d;
      end
    end

    assign ack_out   = sdly_q;
    assign evt_valid = vld_q;
  end else begin : g_4phase
    state_t state_q, state_d;
    logic ack_q, ack_d;
    logic vld_q, vld_d;

    // four-phase handshake next state
    always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      ovf_set = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (sreq) state_d = ST_PEND;
        end
        ST_PEND: begin
          if (!sreq) ovf_set = 1'b1;
          if (evt_ready) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
          end
        end
        ST_ACK: begin
          if (!sreq) begin
            state_d = ST_IDLE;
            ack_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
        end
      endcase
      vld_d = (state_d == ST_PEND);
    end

    // state, ack and valid registers
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= ST_IDLE;
        ack_q   <= 1'b0;
        vld_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        ack_q   <= ack_d;
        vld_q   <= vld_d;
      end
    end

    assign ack_out   = ack_q;
    assign evt_valid = vld_q;
  end

  // sticky error; a new set beats a clear
  always_comb begin
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);
  end

  // error flag register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

endmodule

// File: rtl/req_sync_multi.sv
// Multi-channel request receiver: CH independent channels into clk.
// No arbitration; each channel handshakes on its own.
module req_sync_multi
  import req_sync_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = MODE_4PHASE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] req_in,
  output logic [CH-1:0] ack_out,
  output logic [CH-1:0] evt_valid,
  input  logic [CH-1:0] evt_ready,
  output logic [CH-1:0] ovf,
  input  logic          ovf_clr
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    req_sync_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .MODE       (MODE)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .req_in   (req_in[i]),
      .ack_out  (ack_out[i]),
      .evt_valid(evt_valid[i]),
      .evt_ready(evt_ready[i]),
      .ovf      (ovf[i]),
      .ovf_clr  (ovf_clr)
    );
  end

endmodule

// File: tb/tb_req_sync_multi.sv
// Directed bench for req_sync_multi: four-phase, toggle and
// three-stage synchroniser instances side by side.
module tb_req_sync_multi;
  import req_sync_pkg::*;

  logic clk;
  logic rst;

  logic [3:0] m0_req, m0_ack, m0_vld, m0_rdy, m0_ovf;
  logic       m0_clr;
  logic [3:0] m1_req, m1_ack, m1_vld, m1_rdy, m1_ovf;
  logic       m1_clr;
  logic [3:0] s3_req, s3_ack, s3_vld, s3_rdy, s3_ovf;
  logic       s3_clr;

  int total = 0;
  int bad   = 0;
  int npulse;

  req_sync_multi #(.CH(4), .SYNC_STAGES(2), .MODE(MODE_4PHASE)) u_m0 (
    .clk(clk), .rst(rst), .req_in(m0_req), .ack_out(m0_ack),
    .evt_valid(m0_vld), .evt_ready(m0_rdy), .ovf(m0_ovf),
    .ovf_clr(m0_clr)
  );

  req_sync_multi #(.CH(4), .SYNC_STAGES(2), .MODE(MODE_TOGGLE)) u_m1 (
    .clk(clk), .rst(rst), .req_in(m1_req), .ack_out(m1_ack),
    .evt_valid(m1_vld), .evt_ready(m1_rdy), .ovf(m1_ovf),
    .ovf_clr(m1_clr)
  );

  req_sync_multi #(.CH(4), .SYNC_STAGES(3), .MODE(MODE_4PHASE)) u_s3 (
    .clk(clk), .rst(rst), .req_in(s3_req), .ack_out(s3_ack),
    .evt_valid(s3_vld), .evt_ready(s3_rdy), .ovf(s3_ovf),
    .ovf_clr(s3_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0;
    m0_req = '0; m0_rdy = 4'b0001; m0_clr = 1'b0;
    m1_req = '0; m1_rdy = 4'b1000; m1_clr = 1'b0;
    s3_req = '0; s3_rdy = 4'b0000; s3_clr = 1'b0;
    #12;
    chk("rst_m0_vld", m0_vld, 4'h0);
    chk("rst_m0_ack", m0_ack, 4'h0);
    chk("rst_m1_ovf", m1_ovf, 4'h0);
    rst = 1'b1;
    step(1);

    // four-phase basic on ch0, ready held high
    m0_req[0] = 1'b1;
    step(2);
    chk("b_vld_e2", 4'(m0_vld[0]), 4'h0);
    step(1);
    chk("b_vld_e3", 4'(m0_vld[0]), 4'h1);
    chk("b_ack_e3", 4'(m0_ack[0]), 4'h0);
    step(1);
    chk("b_vld_e4", 4'(m0_vld[0]), 4'h0);
    chk("b_ack_e4", 4'(m0_ack[0]), 4'h1);
    m0_req[0] = 1'b0;
    step(2);
    chk("b_ack_hold", 4'(m0_ack[0]), 4'h1);
    step(1);
    chk("b_ack_drop", 4'(m0_ack[0]), 4'h0);
    chk("b_ovf", m0_ovf, 4'h0);

    // back-pressure on ch1
    m0_req[1] = 1'b1;
    step(3);
    for (int i = 0; i < 10; i++) begin
      chk("bp_vld", 4'(m0_vld[1]), 4'h1);
      chk("bp_ack", 4'(m0_ack[1]), 4'h0);
      step(1);
    end
    m0_rdy[1] = 1'b1;
    step(1);
    chk("bp_ack_rise", 4'(m0_ack[1]), 4'h1);
    chk("bp_vld_fall", 4'(m0_vld[1]), 4'h0);
    m0_rdy[1] = 1'b0;
    m0_req[1] = 1'b0;
    step(3);
    chk("bp_ack_fall", 4'(m0_ack[1]), 4'h0);

    // withdrawn request on ch2
    m0_req[2] = 1'b1;
    step(3);
    chk("v_pend", 4'(m0_vld[2]), 4'h1);
    m0_req[2] = 1'b0;
    step(3);
    chk("v_ovf", 4'(m0_ovf[2]), 4'h1);
    chk("v_vld_kept", 4'(m0_vld[2]), 4'h1);
    m0_rdy[2] = 1'b1;
    step(1);
    m0_rdy[2] = 1'b0;
    chk("v_ack_on", 4'(m0_ack[2]), 4'h1);
    step(1);
    chk("v_ack_off", 4'(m0_ack[2]), 4'h0);
    m0_clr = 1'b1;
    step(1);
    m0_clr = 1'b0;
    chk("v_clr", 4'(m0_ovf[2]), 4'h0);
    m0_req[2] = 1'b1;
    step(3);
    m0_req[2] = 1'b0;
    step(3);
    chk("v2_ovf", 4'(m0_ovf[2]), 4'h1);
    m0_clr = 1'b1;
    step(1);
    m0_clr = 1'b0;
    chk("v2_set_wins", 4'(m0_ovf[2]), 4'h1);
    m0_rdy[2] = 1'b1;
    step(1);
    m0_rdy[2] = 1'b0;
    step(1);
    m0_clr = 1'b1;
    step(1);
    m0_clr = 1'b0;
    chk("v2_clr", 4'(m0_ovf[2]), 4'h0);

    // toggle mode: three events on ch3, ready high
    npulse = 0;
    for (int t = 0; t < 3; t++) begin
      m1_req[3] = ~m1_req[3];
      for (int k = 0; k < 8; k++) begin
        step(1);
        if (m1_vld[3]) npulse++;
      end
    end
    chk("t_pulses", 4'(npulse), 4'h3);
    chk("t_ack_lvl", 4'(m1_ack[3]), 4'h1);
    chk("t_ovf", 4'(m1_ovf[3]), 4'h0);

    // toggle mode overflow on ch2
    m1_req[2] = 1'b1;
    step(4);
    m1_req[2] = 1'b0;
    step(3);
    chk("o_vld", 4'(m1_vld[2]), 4'h1);
    chk("o_ovf", 4'(m1_ovf[2]), 4'h1);
    m1_rdy[2] = 1'b1;
    step(1);
    chk("o_vld_acc", 4'(m1_vld[2]), 4'h0);
    m1_clr = 1'b1;
    step(1);
    m1_clr = 1'b0;
    chk("o_clr", 4'(m1_ovf[2]), 4'h0);
    m1_rdy[2] = 1'b0;
    m1_req[2] = 1'b1;
    step(3);
    chk("o_vld2", 4'(m1_vld[2]), 4'h1);
    m1_req[2] = 1'b0;
    step(2);
    m1_rdy[2] = 1'b1;
    step(1);
    chk("o_same_vld", 4'(m1_vld[2]), 4'h1);
    chk("o_same_ovf", 4'(m1_ovf[2]), 4'h0);
    step(1);
    chk("o_same_drain", 4'(m1_vld[2]), 4'h0);

    // three-stage synchroniser, all channels at once
    s3_rdy = 4'hf;
    s3_req = 4'hf;
    step(3);
    chk("s3_vld_e3", s3_vld, 4'h0);
    step(1);
    chk("s3_vld_e4", s3_vld, 4'hf);
    step(1);
    chk("s3_ack_e5", s3_ack, 4'hf);
    chk("s3_vld_e5", s3_vld, 4'h0);
    s3_req = 4'h0;

    // async reset while ch0 pends and ch1 is acked
    m0_rdy = 4'b0010;
    m0_req[0] = 1'b1;
    m0_req[1] = 1'b1;
    step(4);
    chk("r_pend", 4'(m0_vld[0]), 4'h1);
    chk("r_ack", 4'(m0_ack[1]), 4'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("r_vld0", m0_vld, 4'h0);
    chk("r_ack0", m0_ack, 4'h0);
    chk("r_m1ack", m1_ack, 4'h0);
    m0_req = '0;
    #1;
    rst = 1'b1;
    step(4);
    chk("r_noreplay", m0_vld, 4'h0);
    chk("r_noack", m0_ack, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
